// File: rtl/branch_predictor_nway.sv
// branch_predictor_nway
//   Fetch-stage predictor covering FETCH_WIDTH slots per fetch block. It has
//   per-slot banked BTB (tagged) and BHT (2-bit counter) arrays, a speculative
//   return address stack, and an init FSM that clears the tables after reset.
//   A lookup is issued with pc_cur. The prediction appears one cycle later.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   stall                 hold the lookup register and the pred_* outputs
//   flush                 kill the next prediction; restore RAS sp from cp
//   skip                  suppress pred_valid this cycle
//   bpu_ready             tables initialised (FSM in RUN)
//   pc_cur                fetch address
//   upd_*                 resolved control-flow update (pc, target, type,
//                         direction, counter snapshot)
//   pred_*                prediction: valid, slot, target, type, direction,
//                         counter, delay slot in next line
//
// Init FSM
//   state  | meaning
//   INIT   | clearing one BTB/BHT row per cycle; updates ignored, no predictions
//   RUN    | normal lookup/update operation, bpu_ready=1
module branch_predictor_nway #(
   parameter int FETCH_WIDTH = 2,
   parameter int BTB_SIZE    = 1024,
   parameter int BHT_SIZE    = 4096,
   parameter int TAG_WIDTH   = 10,
   parameter int RAS_DEPTH   = 8,
   parameter int LINE_BYTES  = 32,
   localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              skip,
   output logic              bpu_ready,
   input  logic [31:0]       pc_cur,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic [31:0]       upd_target,
   input  logic [2:0]        upd_cf,
   input  logic              upd_taken,
   input  logic [1:0]        upd_counter,
   output logic              pred_valid,
   output logic [SLOT_W-1:0] pred_slot,
   output logic [31:0]       pred_target,
   output logic [2:0]        pred_cf,
   output logic              pred_taken,
   output logic [1:0]        pred_counter,
   output logic              pred_wait_delayslot
);

   localparam int OFF_W     = $clog2(FETCH_WIDTH);
   localparam int BLK_LSB   = 2 + OFF_W;
   localparam int BTB_ROWS  = BTB_SIZE / FETCH_WIDTH;
   localparam int BHT_ROWS  = BHT_SIZE / FETCH_WIDTH;
   localparam int BTB_RW    = $clog2(BTB_ROWS);
   localparam int BHT_RW    = $clog2(BHT_ROWS);
   localparam int INIT_ROWS = (BTB_ROWS > BHT_ROWS) ? BTB_ROWS : BHT_ROWS;
   localparam int INIT_W    = $clog2(INIT_ROWS);
   localparam int RAS_W     = $clog2(RAS_DEPTH);
   localparam int TAG_LSB   = BLK_LSB + BTB_RW;

   localparam logic [31:0] BLK_MASK  = 32'(4 * FETCH_WIDTH - 1);
   // pc bits above the block offset but inside the cache line
   localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1) & ~BLK_MASK;

   localparam logic [2:0] CF_NONE   = 3'd0;
   localparam logic [2:0] CF_BRANCH = 3'd1;
   localparam logic [2:0] CF_CALL   = 3'd3;
   localparam logic [2:0] CF_RET    = 3'd4;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state;
   logic [INIT_W-1:0] init_row;
   logic              run;

   function automatic logic [SLOT_W-1:0] slot_of(input logic [31:0] pc);
      logic [31:0] t;
      t = (pc >> 2) & 32'(FETCH_WIDTH - 1);
      return t[SLOT_W-1:0];
   endfunction

   // table storage, one bank per slot
   logic                 btb_v   [FETCH_WIDTH][BTB_ROWS];
   logic [TAG_WIDTH-1:0] btb_tag [FETCH_WIDTH][BTB_ROWS];
   logic [2:0]           btb_cf  [FETCH_WIDTH][BTB_ROWS];
   logic [31:0]          btb_tgt [FETCH_WIDTH][BTB_ROWS];
   logic [1:0]           bht     [FETCH_WIDTH][BHT_ROWS];

   // lookup stage register
   logic [31:0]          pc_q;
   logic                 v_q   [FETCH_WIDTH];
   logic [TAG_WIDTH-1:0] tag_q [FETCH_WIDTH];
   logic [2:0]           cf_q  [FETCH_WIDTH];
   logic [31:0]          tgt_q [FETCH_WIDTH];
   logic [1:0]           ctr_q [FETCH_WIDTH];
   logic                 flush_q;

   logic [SLOT_W-1:0]    upd_bank;
   logic [BTB_RW-1:0]    upd_btb_row;
   logic [BHT_RW-1:0]    upd_bht_row;
   logic [1:0]           ctr_nx;
   logic [BTB_RW-1:0]    cur_btb_row;
   logic [BHT_RW-1:0]    cur_bht_row;

   logic                 hit;
   logic [SLOT_W-1:0]    sel;
   logic [SLOT_W-1:0]    off_q;
   logic [2:0]           sel_cf;

   logic [31:0]          ras [RAS_DEPTH];
   logic [RAS_W-1:0]     sp, cp, sp_inc;
   logic [31:0]          ras_top, ret_addr;
   logic                 push, pop;

   logic                 unused_ok;
   assign unused_ok = ^{pc_cur, upd_pc, pc_q};

   assign run = (state == S_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         init_row  <= '0;
         bpu_ready <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               if (init_row == INIT_W'(INIT_ROWS - 1)) begin
                  state     <= S_RUN;
                  bpu_ready <= 1'b1;
               end else begin
                  init_row <= init_row + 1'b1;
               end
            end
            S_RUN: begin
               state     <= S_RUN;
               bpu_ready <= 1'b1;
            end
            default: begin
               state     <= S_INIT;
               bpu_ready <= 1'b0;
            end
         endcase
      end
   end

   assign upd_bank    = slot_of(upd_pc);
   assign upd_btb_row = upd_pc[BLK_LSB +: BTB_RW];
   assign upd_bht_row = upd_pc[BLK_LSB +: BHT_RW];
   assign cur_btb_row = pc_cur[BLK_LSB +: BTB_RW];
   assign cur_bht_row = pc_cur[BLK_LSB +: BHT_RW];

   always_comb begin
      ctr_nx = upd_counter;
      if (upd_taken) begin
         if (upd_counter != 2'b11) ctr_nx = upd_counter + 2'd1;
      end else begin
         if (upd_counter != 2'b00) ctr_nx = upd_counter - 2'd1;
      end
   end

   // Table writes. Reads happen through the stage register on the same edge,
   // so a same-row update is only seen by the following lookup.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT) begin
            for (int b = 0; b < FETCH_WIDTH; b++) begin
               if (int'(init_row) < BTB_ROWS) btb_v[b][init_row[BTB_RW-1:0]] <= 1'b0;
               if (int'(init_row) < BHT_ROWS) bht[b][init_row[BHT_RW-1:0]]   <= 2'b01;
            end
         end else if (upd_valid) begin
            btb_v[upd_bank][upd_btb_row]   <= (upd_cf != CF_NONE);
            btb_tag[upd_bank][upd_btb_row] <= upd_pc[TAG_LSB +: TAG_WIDTH];
            btb_cf[upd_bank][upd_btb_row]  <= upd_cf;
            btb_tgt[upd_bank][upd_btb_row] <= upd_target;
            if (upd_cf == CF_BRANCH) bht[upd_bank][upd_bht_row] <= ctr_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         flush_q <= 1'b0;
         for (int b = 0; b < FETCH_WIDTH; b++) begin
            v_q[b]   <= 1'b0;
            tag_q[b] <= '0;
            cf_q[b]  <= '0;
            tgt_q[b] <= '0;
            ctr_q[b] <= '0;
         end
      end else begin
         flush_q <= flush;
         if (!stall) begin
            pc_q <= pc_cur;
            for (int b = 0; b < FETCH_WIDTH; b++) begin
               v_q[b]   <= btb_v[b][cur_btb_row];
               tag_q[b] <= btb_tag[b][cur_btb_row];
               cf_q[b]  <= btb_cf[b][cur_btb_row];
               tgt_q[b] <= btb_tgt[b][cur_btb_row];
               ctr_q[b] <= bht[b][cur_bht_row];
            end
         end
      end
   end

   assign off_q = slot_of(pc_q);

   // descending scan so the lowest hitting slot at or after the offset wins
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
         if (run && s >= int'(off_q) && v_q[s] &&
             tag_q[s] == pc_q[TAG_LSB +: TAG_WIDTH] && cf_q[s] != CF_NONE) begin
            hit = 1'b1;
            sel = SLOT_W'(s);
         end
      end
   end

   assign sel_cf  = cf_q[sel];
   assign ras_top = ras[sp];

   assign pred_valid   = hit & ~skip & ~flush_q;
   assign pred_slot    = hit ? sel : '0;
   assign pred_cf      = hit ? sel_cf : 3'd0;
   assign pred_counter = hit ? ctr_q[sel] : 2'd0;
   assign pred_taken   = hit & ((sel_cf == CF_BRANCH) ? ctr_q[sel][1] : 1'b1);
   assign pred_target  = !hit ? 32'd0 : ((sel_cf == CF_RET) ? ras_top : tgt_q[sel]);
   assign pred_wait_delayslot = hit && (sel == SLOT_W'(FETCH_WIDTH - 1)) &&
                                ((pc_q & LINE_MASK) == LINE_MASK);

   assign push     = pred_valid && (pred_cf == CF_CALL) && !stall;
   assign pop      = pred_valid && (pred_cf == CF_RET) && !stall;
   assign sp_inc   = sp + 1'b1;
   assign ret_addr = (pc_q & ~BLK_MASK) + (32'(sel) << 2) + 32'd8;

   // Speculative sp moves with predictions; cp follows committed updates.
   // Flush only rewinds sp, entry contents stay as they are.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp <= '0;
         cp <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      end else begin
         if (flush) begin
            sp <= cp;
         end else if (push) begin
            ras[sp_inc] <= ret_addr;
            sp          <= sp_inc;
         end else if (pop) begin
            sp <= sp - 1'b1;
         end
         if (run && upd_valid) begin
            if (upd_cf == CF_CALL)     cp <= cp + 1'b1;
            else if (upd_cf == CF_RET) cp <= cp - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_nway.sv
module tb_branch_predictor_nway;

   localparam int FW          = 2;
   localparam int BTB_SZ      = 1024;
   localparam int BHT_SZ      = 4096;
   localparam int INIT_CYCLES = ((BTB_SZ > BHT_SZ) ? BTB_SZ : BHT_SZ) / FW;
   localparam logic [31:0] IDLE = 32'h0000_0000;

   logic        clk, rst, stall, flush, skip;
   logic        bpu_ready;
   logic [31:0] pc_cur;
   logic        upd_valid;
   logic [31:0] upd_pc, upd_target;
   logic [2:0]  upd_cf;
   logic        upd_taken;
   logic [1:0]  upd_counter;
   logic        pred_valid;
   logic [0:0]  pred_slot;
   logic [31:0] pred_target;
   logic [2:0]  pred_cf;
   logic        pred_taken;
   logic [1:0]  pred_counter;
   logic        pred_wait_delayslot;

   branch_predictor_nway dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .skip(skip),
      .bpu_ready(bpu_ready), .pc_cur(pc_cur),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_cf(upd_cf), .upd_taken(upd_taken), .upd_counter(upd_counter),
      .pred_valid(pred_valid), .pred_slot(pred_slot), .pred_target(pred_target),
      .pred_cf(pred_cf), .pred_taken(pred_taken), .pred_counter(pred_counter),
      .pred_wait_delayslot(pred_wait_delayslot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [0:0]  slot;
      logic [31:0] target;
      logic [2:0]  cf;
      logic        taken;
      logic [1:0]  counter;
      logic        wds;
   } pred_t;

   typedef struct packed {
      logic        do_upd;
      logic [31:0] u_pc;
      logic [31:0] u_tgt;
      logic [2:0]  u_cf;
      logic        u_taken;
      logic [1:0]  u_ctr;
      logic [31:0] l_pc;
      pred_t       exp;
   } vec_t;

   pred_t sb[$];
   vec_t  vecs[14];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic pred_t P(input logic v, input logic s, input logic [31:0] t,
                               input logic [2:0] cf, input logic tk,
                               input logic [1:0] c, input logic w);
      pred_t r;
      r.valid = v; r.slot = s; r.target = t; r.cf = cf;
      r.taken = tk; r.counter = c; r.wds = w;
      return r;
   endfunction

   function automatic vec_t V(input logic d, input logic [31:0] upc, input logic [31:0] utgt,
                              input logic [2:0] ucf, input logic utk, input logic [1:0] uctr,
                              input logic [31:0] lpc, input pred_t e);
      vec_t r;
      r.do_upd = d; r.u_pc = upc; r.u_tgt = utgt; r.u_cf = ucf;
      r.u_taken = utk; r.u_ctr = uctr; r.l_pc = lpc; r.exp = e;
      return r;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name);
      pred_t e, a;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s: no expected entry queued", name);
         return;
      end
      e = sb.pop_front();
      a = {pred_valid, pred_slot, pred_target, pred_cf, pred_taken, pred_counter,
           pred_wait_delayslot};
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got v=%0b s=%0d t=%h cf=%0d tk=%0b c=%b w=%0b, need v=%0b s=%0d t=%h cf=%0d tk=%0b c=%b w=%0b",
                  name, a.valid, a.slot, a.target, a.cf, a.taken, a.counter, a.wds,
                  e.valid, e.slot, e.target, e.cf, e.taken, e.counter, e.wds);
      end
   endtask

   task automatic cmp_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] cf,
                         input logic tk, input logic [1:0] ctr);
      upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_cf = cf;
      upd_taken = tk; upd_counter = ctr;
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input pred_t e, input string name);
      pc_cur = pc;
      sb.push_back(e);
      tick();
      pc_cur = IDLE;
      check(name);
   endtask

   task automatic wait_ready(output int cnt, output int pv_seen);
      cnt = 0;
      pv_seen = 0;
      while (!bpu_ready && cnt < 5000) begin
         if (pred_valid) pv_seen++;
         cnt++;
         tick();
      end
   endtask

   int    cnt, pv;
   pred_t miss, j1000, call3000, callA004;

   initial begin
      miss     = P(0, 0, 32'h0, 0, 0, 2'b00, 0);
      j1000    = P(1, 0, 32'h8000_4000, 2, 1, 2'b01, 0);
      call3000 = P(1, 0, 32'h8000_8000, 3, 1, 2'b01, 0);
      callA004 = P(1, 1, 32'h8000_B000, 3, 1, 2'b01, 0);

      vecs[0]  = V(1, 32'h8000_1004, 32'h8000_2000, 1, 1, 2'b01, 32'h8000_1000,
                   P(1, 1, 32'h8000_2000, 1, 1, 2'b10, 0));
      vecs[1]  = V(1, 32'h8000_1000, 32'h8000_4000, 2, 1, 2'b00, 32'h8000_1000, j1000);
      vecs[2]  = V(1, 32'h8000_1004, 32'h8000_5000, 2, 1, 2'b00, 32'h8000_1004,
                   P(1, 1, 32'h8000_5000, 2, 1, 2'b10, 0));
      vecs[3]  = V(0, 0, 0, 0, 0, 0, 32'h8000_1000, j1000);
      vecs[4]  = V(0, 0, 0, 0, 0, 0, 32'h8000_2000, miss);
      vecs[5]  = V(1, 32'h8000_1004, 32'h0, 0, 0, 2'b00, 32'h8000_1004, miss);
      vecs[6]  = V(1, 32'h8000_101C, 32'h8000_6000, 2, 1, 2'b00, 32'h8000_101C,
                   P(1, 1, 32'h8000_6000, 2, 1, 2'b01, 1));
      vecs[7]  = V(1, 32'h8000_1014, 32'h8000_6100, 2, 1, 2'b00, 32'h8000_1010,
                   P(1, 1, 32'h8000_6100, 2, 1, 2'b01, 0));
      vecs[8]  = V(1, 32'h8000_1020, 32'h8000_7000, 1, 0, 2'b01, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 0, 2'b00, 0));
      vecs[9]  = V(1, 32'h8000_1020, 32'h8000_7000, 1, 0, 2'b00, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 0, 2'b00, 0));
      vecs[10] = V(1, 32'h8000_1020, 32'h8000_7000, 1, 1, 2'b11, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 1, 2'b11, 0));
      vecs[11] = V(1, 32'h8000_1020, 32'h8000_7000, 1, 1, 2'b10, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 1, 2'b11, 0));
      vecs[12] = V(1, 32'h8000_1020, 32'h8000_7000, 1, 0, 2'b11, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 1, 2'b10, 0));
      vecs[13] = V(1, 32'h8000_1020, 32'h8000_7000, 1, 1, 2'b00, 32'h8000_1020,
                   P(1, 0, 32'h8000_7000, 1, 0, 2'b01, 0));

      rst = 1'b1; stall = 1'b0; flush = 1'b0; skip = 1'b0;
      pc_cur = IDLE; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
      upd_cf = '0; upd_taken = 1'b0; upd_counter = '0;
      repeat (3) tick();

      sb.push_back(miss);
      check("reset_outputs");
      cmp_int("reset_ready", int'(bpu_ready), 0);

      // init window with a live update and lookup that must both be ignored
      pc_cur = 32'h8000_1000;
      upd_valid = 1'b1; upd_pc = 32'h8000_1000; upd_target = 32'h8000_4000;
      upd_cf = 3'd2; upd_taken = 1'b1;
      rst = 1'b0;
      wait_ready(cnt, pv);
      upd_valid = 1'b0;
      pc_cur = IDLE;
      cmp_int("init_cycles", cnt, INIT_CYCLES);
      cmp_int("init_no_pred", pv, 0);
      lookup(32'h8000_1000, miss, "init_upd_ignored");

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].do_upd)
            do_upd(vecs[i].u_pc, vecs[i].u_tgt, vecs[i].u_cf, vecs[i].u_taken, vecs[i].u_ctr);
         lookup(vecs[i].l_pc, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // same-row update and lookup in one cycle: old entry predicted
      pc_cur = 32'h8000_1018;
      upd_valid = 1'b1; upd_pc = 32'h8000_101C; upd_target = 32'h8000_6200;
      upd_cf = 3'd2; upd_taken = 1'b1; upd_counter = 2'b00;
      sb.push_back(P(1, 1, 32'h8000_6000, 2, 1, 2'b01, 1));
      tick();
      upd_valid = 1'b0;
      pc_cur = IDLE;
      check("read_first_old");
      lookup(32'h8000_1018, P(1, 1, 32'h8000_6200, 2, 1, 2'b01, 1), "read_first_new");

      // stall holds outputs for 3 cycles despite a new pc_cur
      pc_cur = 32'h8000_1018;
      sb.push_back(P(1, 1, 32'h8000_6200, 2, 1, 2'b01, 1));
      tick();
      check("stall_pre");
      pc_cur = 32'h8000_1000;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(P(1, 1, 32'h8000_6200, 2, 1, 2'b01, 1));
         tick();
         check($sformatf("stall_hold%0d", i));
      end
      stall = 1'b0;
      sb.push_back(j1000);
      tick();
      pc_cur = IDLE;
      check("stall_release");

      // skip only masks pred_valid
      pc_cur = 32'h8000_1000;
      tick();
      pc_cur = IDLE;
      skip = 1'b1;
      #1;
      sb.push_back(P(0, 0, 32'h8000_4000, 2, 1, 2'b01, 0));
      check("skip_masks");
      skip = 1'b0;
      #1;
      sb.push_back(j1000);
      check("skip_release");

      // flush kills the prediction of the following cycle
      tick();
      pc_cur = 32'h8000_1000;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      pc_cur = IDLE;
      sb.push_back(P(0, 0, 32'h8000_4000, 2, 1, 2'b01, 0));
      check("flush_kill");
      lookup(32'h8000_1000, j1000, "flush_recover");

      // RAS: train two calls and a return twice (cp returns to 0)
      do_upd(32'h8000_3000, 32'h8000_8000, 3, 1, 2'b00);
      do_upd(32'h8000_A004, 32'h8000_B000, 3, 1, 2'b00);
      do_upd(32'h8000_9010, 32'h0, 4, 1, 2'b00);
      do_upd(32'h8000_9010, 32'h0, 4, 1, 2'b00);
      lookup(32'h8000_3000, call3000, "ras_call0");
      lookup(32'h8000_A004, callA004, "ras_call1");
      lookup(32'h8000_9010, P(1, 0, 32'h8000_A00C, 4, 1, 2'b01, 0), "ras_ret1");
      lookup(32'h8000_9010, P(1, 0, 32'h8000_3008, 4, 1, 2'b01, 0), "ras_ret0");

      // commit one call, speculate a second, flush: sp back to committed top
      lookup(32'h8000_3000, call3000, "ras_call_commit");
      do_upd(32'h8000_3000, 32'h8000_8000, 3, 1, 2'b00);
      lookup(32'h8000_A004, callA004, "ras_call_spec");
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      lookup(32'h8000_9010, P(1, 0, 32'h8000_3008, 4, 1, 2'b01, 0), "ras_flush_restore");

      // reset mid-operation re-enters INIT and clears the tables
      rst = 1'b1;
      tick();
      sb.push_back(miss);
      check("midrst_outputs");
      cmp_int("midrst_ready", int'(bpu_ready), 0);
      rst = 1'b0;
      wait_ready(cnt, pv);
      cmp_int("midrst_init_cycles", cnt, INIT_CYCLES);
      lookup(32'h8000_1000, miss, "midrst_cleared");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
